// File: rtl/ej32_fetch.sv
// eJ32 instruction-byte prefetch: streams bytecode from memory into a FIFO for decode/branch.
// Define EJ32_PREFETCH_EN for a DEPTH-entry FIFO; otherwise a single holding byte is used.
module ej32_fetch #(
  parameter int ASZ   = 17,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           jmp_en,
  input  logic [ASZ-1:0] jmp_p,
  output logic           mem_req,
  output logic [ASZ-1:0] mem_a,
  input  logic           mem_ack,
  input  logic [7:0]     mem_d,
  output logic           q_vld,
  output logic [7:0]     q_byte,
  output logic [ASZ-1:0] q_p,
  input  logic           q_take
);

`ifdef EJ32_PREFETCH_EN
  localparam int D = DEPTH;
`else
  localparam int D = 1;
`endif
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(D);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ej32_fetch: DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {REDIR, FILL, FULL} state_t;

  state_t         state;
  logic [ASZ-1:0] fa;
  logic [ASZ-1:0] head_p;
  logic [7:0]     fifo [2**PW];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  cnt;
  logic           push;
  logic           pop;

  // A single-entry FIFO keeps both pointers pinned at zero.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (D == 1) ? '0 : PW'(p + 1'b1);
  endfunction

  assign mem_req = (state == FILL);
  assign mem_a   = fa;
  assign q_p     = head_p;
  assign q_vld   = (cnt != '0);
  assign q_byte  = fifo[rd_ptr];

  // A redirect cycle swallows any ack and any take.
  assign push = mem_req && mem_ack && !jmp_en;
  assign pop  = q_take && q_vld && !jmp_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= REDIR;
      fa     <= '0;
      head_p <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < 2**PW; i++) fifo[PW'(i)] <= '0;
    end else if (jmp_en) begin
      state  <= REDIR;
      fa     <= jmp_p;
      head_p <= jmp_p;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= mem_d;
        wr_ptr       <= ptr_inc(wr_ptr);
        fa           <= fa + 1'b1;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        head_p <= head_p + 1'b1;
      end
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;

      case (state)
        REDIR:   state <= FILL;
        FILL:    if (push && !pop && cnt == FULL_CNT - 1'b1) state <= FULL;
        FULL:    if (pop) state <= FILL;
        default: state <= REDIR;
      endcase
    end
  end

endmodule

// File: tb/tb_ej32_fetch.sv
// Randomized scoreboard bench for ej32_fetch: expected bytes are queued on accepted acks and
// compared, in order, against what the fetch stage presents to the decoder.
module tb_ej32_fetch;

`ifdef EJ32_PREFETCH_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic        clk;
  logic        rst;
  logic        jmp_en;
  logic [16:0] jmp_p;
  logic        mem_req;
  logic [16:0] mem_a;
  logic        mem_ack;
  logic [7:0]  mem_d;
  logic        q_vld;
  logic [7:0]  q_byte;
  logic [16:0] q_p;
  logic        q_take;

  int total = 0;
  int bad   = 0;

  ej32_fetch #(.ASZ(17), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .jmp_en(jmp_en), .jmp_p(jmp_p),
    .mem_req(mem_req), .mem_a(mem_a), .mem_ack(mem_ack), .mem_d(mem_d),
    .q_vld(q_vld), .q_byte(q_byte), .q_p(q_p), .q_take(q_take)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a fixed byte per address (low addresses read back as i & 0xFF).
  function automatic logic [7:0] mfunc(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]};
  endfunction

  assign mem_d = mfunc(mem_a);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: stream of (address, byte) pairs owed to the consumer, the next
  // address to fetch, and whether this cycle follows a redirect/reset.
  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t        sbq[$];
  logic [16:0] mfa   = '0;
  bit          redir = 1'b1;
  bit          armed = 1'b0;
  bit          chk_rst = 1'b0;

  always @(negedge clk) begin
    bit   er;
    bit   ev;
    ent_t e;
    if (armed) begin
      er = !redir && (sbq.size() < D);
      ev = (sbq.size() != 0);
      if (chk_rst) begin
        check("rst_mem_a", 32'(mem_a), 32'd0);
        check("rst_q_byte", 32'(q_byte), 32'd0);
        check("rst_q_p", 32'(q_p), 32'd0);
      end
      check("mem_req", 32'(mem_req), 32'(er));
      if (er) check("mem_a", 32'(mem_a), 32'(mfa));
      check("q_vld", 32'(q_vld), 32'(ev));
      if (ev && q_vld) begin
        check("q_p", 32'(q_p), 32'(sbq[0].a));
        check("q_byte", 32'(q_byte), 32'(sbq[0].d));
      end
      chk_rst = 1'b0;
      if (!rst && !jmp_en) begin
        redir = 1'b0;
        if (q_take && ev) begin
          $display("pop q_p=%05h byte=%02h", sbq[0].a, sbq[0].d);
          void'(sbq.pop_front());
        end
        if (er && mem_ack) begin
          e.a = mfa;
          e.d = mfunc(mfa);
          sbq.push_back(e);
          mfa = mfa + 17'd1;
        end
      end
    end
    if (rst) begin
      sbq.delete();
      mfa     = '0;
      redir   = 1'b1;
      armed   = 1'b1;
      chk_rst = 1'b1;
    end else if (jmp_en && armed) begin
      $display("jump to %05h", jmp_p);
      sbq.delete();
      mfa   = jmp_p;
      redir = 1'b1;
    end
  end

  task automatic cyc(input logic r, input logic j, input logic [16:0] jp,
                     input logic ack, input logic take);
    @(posedge clk);
    #1;
    rst     = r;
    jmp_en  = j;
    jmp_p   = jp;
    mem_ack = ack;
    q_take  = take;
  endtask

  initial begin
    rst = 1'b1; jmp_en = 1'b0; jmp_p = '0; mem_ack = 1'b0; q_take = 1'b0;
    repeat (3) cyc(1, 0, 0, 0, 0);
    // Streaming from reset with constant ack and take.
    repeat (40) cyc(0, 0, 0, 1, 1);
    // Fill until full, single take, then fill again.
    repeat (10) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    repeat (4) cyc(0, 0, 0, 1, 0);
    // Ack stall at 0x00010 with the FIFO draining.
    cyc(0, 1, 17'h0000E, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0, 1);
    // Jump while bytes are buffered and an ack lands in the jump cycle.
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 17'h01234, 1, 1);
    repeat (8) cyc(0, 0, 0, 1, 1);
    // Address wrap at the top of the space.
    cyc(0, 1, 17'h1FFFE, 1, 1);
    repeat (10) cyc(0, 0, 0, 1, 1);
    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [16:0] jp;
      jp = ($urandom_range(3) == 0) ? 17'h1FFFC + 17'($urandom_range(3)) : 17'($urandom);
      cyc(($urandom_range(299) == 0), ($urandom_range(39) == 0), jp,
          ($urandom_range(3) != 0), ($urandom_range(2) != 0));
    end
    // Reset with bytes buffered and a request outstanding.
    cyc(0, 1, 17'h00040, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    repeat (6) cyc(0, 0, 0, 1, 1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
